bp_be_dep_tracker: RTL



---
 rtl/bp_be_pkg.sv | 35 +++
 rtl/bp_be_dep_tracker_if.sv | 29 ++
 rtl/bp_be_mem_credit_counter.sv | 48 ++++
 rtl/bp_be_dep_tracker.sv | 93 +++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared backend types for the dependency scoreboard and the hazard detector.
package bp_be_pkg;

  localparam int rf_addr_width_gp = 5;

  typedef struct packed {
    logic mul_iwb_v;
    logic mem_iwb_v;
    logic mem_fwb_v;
    logic fp_fwb_v;
    logic serial_v;
    logic mem_v;
    logic long_v;
  } bp_be_dep_tag_s;

  typedef struct packed {
    logic                        v;
    logic [rf_addr_width_gp-1:0] rd_addr;
    logic                        mul_iwb_v;
    logic                        mem_iwb_v;
    logic                        mem_fwb_v;
    logic                        fp_fwb_v;
    logic                        serial_v;
    logic                        mem_v;
  } bp_be_dep_status_s;

  typedef enum logic {e_long_idle, e_long_busy} bp_be_long_state_e;

  // Status flags are the dispatch tag minus long_v, in the same bit order.
  function automatic bp_be_dep_status_s dep_entry(logic [rf_addr_width_gp-1:0] rd_addr,
                                                  logic [5:0]                  wb_flags);
    return bp_be_dep_status_s'({1'b1, rd_addr, wb_flags});
  endfunction

endpackage

// File: rtl/bp_be_dep_tracker_if.sv
// Dispatch/flush/response inputs and scoreboard outputs of the dependency tracker.
interface bp_be_dep_tracker_if #(
  parameter int pipe_depth_p    = 6,
  parameter int rf_addr_width_p = 5
);
  import bp_be_pkg::*;

  logic                                 dispatch_v_i;
  logic [rf_addr_width_p-1:0]           dispatch_rd_addr_i;
  bp_be_dep_tag_s                       dispatch_tag_i;
  logic                                 flush_i;
  logic                                 mem_resp_v_i;
  logic                                 long_done_i;
  bp_be_dep_status_s [pipe_depth_p-1:0] dep_status_o;
  logic                                 long_busy_o;
  logic                                 credits_full_o;
  logic                                 credits_empty_o;

  modport master (
    output dispatch_v_i, dispatch_rd_addr_i, dispatch_tag_i, flush_i, mem_resp_v_i, long_done_i,
    input  dep_status_o, long_busy_o, credits_full_o, credits_empty_o
  );

  modport slave (
    input  dispatch_v_i, dispatch_rd_addr_i, dispatch_tag_i, flush_i, mem_resp_v_i, long_done_i,
    output dep_status_o, long_busy_o, credits_full_o, credits_empty_o
  );

endinterface

// File: rtl/bp_be_mem_credit_counter.sv
// Saturating outstanding-memory-op counter: one increment and a 0-3 decrement per cycle.
module bp_be_mem_credit_counter #(
  parameter int max_p = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic [1:0] dec,
  output logic       full,
  output logic       empty
);

  localparam int cnt_w_lp = $clog2(max_p + 1);

  logic        [cnt_w_lp-1:0] count;
  logic signed [cnt_w_lp+1:0] sum_s;

  function automatic logic [cnt_w_lp-1:0] sat_count(logic signed [cnt_w_lp+1:0] s);
    if (s < 0)
      return '0;
    else if (s > max_p)
      return cnt_w_lp'(max_p);
    else
      return s[cnt_w_lp-1:0];
  endfunction

  assign sum_s = $signed({2'b00, count})
               + $signed({{(cnt_w_lp+1){1'b0}}, inc})
               - $signed({{cnt_w_lp{1'b0}}, dec});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else
      count <= sat_count(sum_s);
  end

  assign full  = (count == cnt_w_lp'(max_p));
  assign empty = (count == '0);

  always @(posedge clk) begin
    if (reset_n) begin
      assert (sum_s >= 0);
      assert (sum_s <= max_p);
    end
  end

endmodule

// File: rtl/bp_be_dep_tracker.sv
// Dependency scoreboard: shadows dispatched tags down the pipe, tracks the long-latency
// unit and the outstanding memory credits.
module bp_be_dep_tracker #(
  parameter int pipe_depth_p    = 6,
  parameter int rf_addr_width_p = 5,
  parameter int mem_credits_p   = 8
) (
  input logic               clk_i,
  input logic               reset_n_i,
  bp_be_dep_tracker_if.slave dep_if
);
  import bp_be_pkg::*;

  localparam int commit_stage_lp = 2;

  bp_be_dep_status_s [pipe_depth_p-1:0] stage_p0, stage_n;
  logic              [1:0]              long_p0, long_n;
  bp_be_long_state_e                    state_r, state_n;
  logic [rf_addr_width_p-1:0]           rd_addr;
  logic                                 dispatch_live;
  logic                                 kill0, kill1;
  logic [1:0]                           dec_cnt;

  assign rd_addr       = dep_if.dispatch_rd_addr_i;
  assign dispatch_live = dep_if.dispatch_v_i & ~dep_if.flush_i;

  // Shift stage: a flush zeroes whatever would land in the speculative stages or the commit point.
  always_comb begin
    stage_n    = '0;
    stage_n[0] = dispatch_live ? dep_entry(rd_addr, dep_if.dispatch_tag_i[6:1]) : '0;
    for (int i = 1; i < pipe_depth_p; i++)
      stage_n[i] = (dep_if.flush_i && i <= commit_stage_lp) ? '0 : stage_p0[i-1];
    long_n = {~dep_if.flush_i & long_p0[0], dispatch_live & dep_if.dispatch_tag_i.long_v};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stage_p0 <= '0;
      long_p0  <= '0;
    end else begin
      stage_p0 <= stage_n;
      long_p0  <= long_n;
    end
  end

  // Flushed speculative mem ops never produce a response, so their credits come back here.
  assign kill0   = dep_if.flush_i & stage_p0[0].v & stage_p0[0].mem_v;
  assign kill1   = dep_if.flush_i & stage_p0[1].v & stage_p0[1].mem_v;
  assign dec_cnt = {1'b0, kill0} + {1'b0, kill1} + {1'b0, dep_if.mem_resp_v_i};

  bp_be_mem_credit_counter #(
    .max_p(mem_credits_p)
  ) credit_counter (
    .clk    (clk_i),
    .reset_n(reset_n_i),
    .inc    (dispatch_live & dep_if.dispatch_tag_i.mem_v),
    .dec    (dec_cnt),
    .full   (dep_if.credits_full_o),
    .empty  (dep_if.credits_empty_o)
  );

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_long_idle:
        if (dispatch_live & dep_if.dispatch_tag_i.long_v)
          state_n = e_long_busy;
      e_long_busy:
        if (dep_if.long_done_i | (dep_if.flush_i & |long_p0))
          state_n = e_long_idle;
      default:
        state_n = e_long_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      state_r <= e_long_idle;
    else
      state_r <= state_n;
  end

  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(state_r == e_long_idle && dep_if.long_done_i));
      assert (!(state_r == e_long_busy && dispatch_live && dep_if.dispatch_tag_i.long_v));
    end
  end

  assign dep_if.dep_status_o = stage_p0;
  assign dep_if.long_busy_o  = (state_r == e_long_busy);

endmodule
